seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, pipelined successor to the team's single-cycle combinational ALU.
- Adds a valid/ready handshake, a registered output with backpressure, arithmetic shift and signed compare, and iterative multi-cycle MUL/MULHU/DIVU/REMU.
- Sits in the execute stage. The core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, datapath width in bits; must be >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept this cycle.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- alu_ctrl  in  4  operation select.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- alu_result  out  WIDTH  result.
- eq  out  1  src_a == src_b, registered with the result.
- gt  out  1  src_a > src_b unsigned, registered with the result.
- lt  out  1  src_a < src_b unsigned, registered with the result.
- lt_s  out  1  src_a < src_b signed, registered with the result.
- busy  out  1  multi-cycle operation in progress.

Behaviour:
- Op encoding (alu_ctrl):
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND.
  - 5 SLL, 6 SRL, 7 SLTU (zero-extended 0/1).
  - 8 SRA, 9 SLT signed.
  - 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned).
  - 12 DIVU, 13 REMU.
  - 14, 15 reserved: treated as ADD.
- Shifts use src_b[SHW-1:0] only; upper bits ignored. ADD/SUB wrap modulo 2^WIDTH.
- Accept: transfer occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Flags eq/gt/lt/lt_s are computed from the accepted operands and loaded into the output register with the result, for every op.
- Ops 0-9 and 14-15: result registered at accept. out_valid rises the next cycle (latency 1). Back-to-back accepts give throughput 1/cycle when out_ready is held high.
- Ops 10-13 follow the FSM below.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL on accepting op 10/11. Latches operands, clears the 2*WIDTH accumulator, cnt=WIDTH.
  - IDLE -> DIV on accepting op 12/13. Restoring division; partial remainder 0, cnt=WIDTH.
  - MUL: one shift-add per cycle.
  - DIV: one quotient bit per cycle.
  - cnt decrements each cycle. At cnt==1, load the output register, set out_valid and return to IDLE.
  - Latency is WIDTH cycles from accept to out_valid.
  - busy = (state != IDLE).
- Divide by zero: runs the full WIDTH iterations. DIVU result is all ones; REMU result is src_a. No exception.
- Output register: holds alu_result, flags and out_valid unchanged while out_valid && !out_ready.
  - Cleared (out_valid=0) on out_ready when no new result loads the same cycle.
  - Simultaneous drain and load: the new result wins and out_valid stays 1.
- The output register is guaranteed empty when a multi-cycle op completes, because accept required an empty or draining register. No DONE state is needed.
- in_valid while busy: ignored (in_ready=0). Inputs are not sampled.
- Reset (any time, including mid-iteration):
  - state=IDLE, cnt=0, accumulators 0.
  - out_valid=0, alu_result=0, eq=gt=lt=lt_s=0, busy=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Any in-flight op is discarded.

Decomposition:
- Package seq_alu_pkg holds:
  - the alu_ctrl op localparams (OP_ADD..OP_REMU);
  - the FSM state encoding (S_IDLE, S_MUL, S_DIV).
- One sub-module, seq_alu_muldiv: iterative multiply/divide engine with start/done/result. The top holds the handshake, the single-cycle ops and the output register.

Test Plan:
- ADD with src_a=32'hFFFFFFFF, src_b=1, out_ready=1 -> next cycle out_valid=1, alu_result=0, gt=1, lt=0, lt_s=1.
- SRA with src_a=32'h80000000, src_b=32'h00000024 (shamt 4) -> 32'hF8000000. SRL with the same operands -> 32'h08000000.
- MUL with src_a=32'h00010000, src_b=32'h00030000 -> out_valid exactly 32 cycles after accept, result 0. MULHU with the same operands -> 32'h00000003. in_ready=0 and busy=1 throughout.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 5/0 -> 32'hFFFFFFFF; REMU 5/0 -> 5.
- Backpressure: hold out_ready=0, accept ADD 1+2 -> alu_result=3 held stable. in_ready=0 until out_ready=1. On that cycle a new SUB 5-3 is accepted and 2 appears next cycle with out_valid continuously 1.
- Assert rst at iteration 10 of a DIVU -> immediately out_valid=0, busy=0, alu_result=0. After release, ADD 2+2 -> 4 with latency 1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
//   Shared definitions for the sequential ALU: operation encodings on
//   alu_ctrl, the multiply/divide FSM state encoding and the compare-flag
//   bundle that travels with each result.
// -----------------------------------------------------------------------------
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
    logic lt_s;
  } flags_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// -----------------------------------------------------------------------------
// seq_alu_muldiv
//   Iterative unsigned multiply (shift-add) and restoring divide engine.
//   One bit per cycle; done_o pulses combinationally on the last iteration
//   with result_o valid in that same cycle, so the caller registers it.
//   Ports:
//     clk, rst          clock, async active-high reset
//     start_i           accept a new op (only honoured when idle)
//     op_i              OP_MUL / OP_MULHU / OP_DIVU / OP_REMU
//     a_i, b_i          operands
//     busy_o            iteration in progress
//     done_o            final iteration this cycle
//     result_o          result, valid while done_o
// -----------------------------------------------------------------------------
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNTW = $clog2(WIDTH + 1);

  // acc_q is shared: MUL keeps {partial product, remaining multiplier bits};
  // DIV keeps {partial remainder, dividend bits shifting into quotient}.
  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
  logic               hi_q, hi_d;       // result taken from upper half

  logic               is_div;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] step_acc;

  assign is_div = (op_i == OP_DIVU) || (op_i == OP_REMU);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can leave a latch behind.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    done_o   = 1'b0;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (state_q == S_DIV) begin
      // Borrow out means the trial subtraction failed: restore, quotient bit 0.
      step_acc = div_diff[WIDTH] ? {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = is_div ? S_DIV : S_MUL;
          cnt_d   = CNTW'(WIDTH);
          acc_d   = {{WIDTH{1'b0}}, (is_div ? a_i : b_i)};
          opnd_d  = is_div ? b_i : a_i;
          hi_d    = (op_i == OP_MULHU) || (op_i == OP_REMU);
        end
      end
      S_MUL, S_DIV: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    result_o = hi_q ? step_acc[2*WIDTH-1:WIDTH] : step_acc[WIDTH-1:0];
  end

  assign busy_o = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Pipelined execute-stage ALU with valid/ready on both sides. Single-cycle
//   ops register their result at accept; MUL/MULHU/DIVU/REMU run WIDTH
//   cycles in seq_alu_muldiv. Compare flags are captured from the accepted
//   operands and presented with the result.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     in_valid / in_ready      input handshake
//     src_a, src_b, alu_ctrl   operands and op select
//     out_valid / out_ready    output handshake
//     alu_result               registered result
//     eq, gt, lt, lt_s         registered compare flags
//     busy                     multi-cycle op in progress
// -----------------------------------------------------------------------------
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             lt_s,
  output logic             busy
);

  logic             accept;
  logic             is_multi;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_comb;
  flags_t           flags_now;

  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;
  flags_t           flags_hold_q, flags_hold_d;  // flags of the in-flight multi-cycle op
  logic             out_valid_q, out_valid_d;

  assign is_multi = (alu_ctrl == OP_MUL)  || (alu_ctrl == OP_MULHU) ||
                    (alu_ctrl == OP_DIVU) || (alu_ctrl == OP_REMU);
  assign in_ready = !md_busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = src_b[SHW-1:0];

  always_comb begin
    flags_now.eq   = (src_a == src_b);
    flags_now.gt   = (src_a > src_b);
    flags_now.lt   = (src_a < src_b);
    flags_now.lt_s = ($signed(src_a) < $signed(src_b));
  end

  always_comb begin
    unique case (alu_ctrl)
      OP_SUB:  alu_comb = src_a - src_b;
      OP_XOR:  alu_comb = src_a ^ src_b;
      OP_OR:   alu_comb = src_a | src_b;
      OP_AND:  alu_comb = src_a & src_b;
      OP_SLL:  alu_comb = src_a << shamt;
      OP_SRL:  alu_comb = src_a >> shamt;
      OP_SRA:  alu_comb = $signed(src_a) >>> shamt;
      OP_SLTU: alu_comb = {{(WIDTH-1){1'b0}}, flags_now.lt};
      OP_SLT:  alu_comb = {{(WIDTH-1){1'b0}}, flags_now.lt_s};
      default: alu_comb = src_a + src_b;  // ADD, reserved codes, multi-cycle ops
    endcase
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (accept && is_multi),
    .op_i     (alu_ctrl),
    .a_i      (src_a),
    .b_i      (src_b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result)
  );

  // A load (new single-cycle result or muldiv completion) overrides the
  // drain, so a simultaneous drain and load keeps out_valid high.
  always_comb begin
    result_d     = result_q;
    flags_d      = flags_q;
    flags_hold_d = flags_hold_q;
    out_valid_d  = out_valid_q;
    if (out_ready) out_valid_d = 1'b0;
    if (accept && is_multi) flags_hold_d = flags_now;
    if (accept && !is_multi) begin
      result_d    = alu_comb;
      flags_d     = flags_now;
      out_valid_d = 1'b1;
    end else if (md_done) begin
      result_d    = md_result;
      flags_d     = flags_hold_q;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q     <= '0;
      flags_q      <= '0;
      flags_hold_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      result_q     <= result_d;
      flags_q      <= flags_d;
      flags_hold_q <= flags_hold_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign eq         = flags_q.eq;
  assign gt         = flags_q.gt;
  assign lt         = flags_q.lt;
  assign lt_s       = flags_q.lt_s;
  assign busy       = md_busy;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Scoreboard bench for seq_alu (WIDTH=32). Expected results are pushed when
//   an accept is observed and compared when the DUT transfers a result.
// -----------------------------------------------------------------------------
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         eq;
    logic         gt;
    logic         lt;
    logic         lt_s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [3:0]   alu_ctrl = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_result;
  logic         eq, gt, lt, lt_s;
  logic         busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_ctrl   (alu_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .eq         (eq),
    .gt         (gt),
    .lt         (lt),
    .lt_s       (lt_s),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    p      = {32'b0, a} * {32'b0, b};
    e.eq   = (a == b);
    e.gt   = (a > b);
    e.lt   = (a < b);
    e.lt_s = ($signed(a) < $signed(b));
    case (op)
      4'd1:    e.res = a - b;
      4'd2:    e.res = a ^ b;
      4'd3:    e.res = a | b;
      4'd4:    e.res = a & b;
      4'd5:    e.res = a << b[4:0];
      4'd6:    e.res = a >> b[4:0];
      4'd7:    e.res = (a < b) ? 32'd1 : 32'd0;
      4'd8:    e.res = $signed(a) >>> b[4:0];
      4'd9:    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10:   e.res = p[31:0];
      4'd11:   e.res = p[63:32];
      4'd12:   e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13:   e.res = (b == 0) ? a : a % b;
      default: e.res = a + b;
    endcase
    return e;
  endfunction

  // Transfer monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {28'b0, alu_result, eq, gt, lt, lt_s}, 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {28'b0, alu_result, eq, gt, lt, lt_s}, {28'b0, e});
      end
    end
  end

  // Presents one op starting just after a rising edge and returns just
  // after the edge that accepted it; in_valid is dropped on return.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit done = 0;
    in_valid = 1'b1;
    alu_ctrl = op;
    src_a    = a;
    src_b    = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(op, a, b));
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    check("drain", sb.size(), 0);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int bad;
    logic [3:0]   ops [11] = '{OP_SRA, OP_SRL, OP_SUB, OP_XOR, OP_OR, OP_AND,
                               OP_SLL, OP_SLTU, OP_SLT, 4'd14, 4'd15};
    logic [W-1:0] as  [11] = '{32'h8000_0000, 32'h8000_0000, 32'd3, 32'hF0F0_1234,
                               32'h0000_FF00, 32'hFFFF_0F0F, 32'h0000_0003, 32'h0000_0001,
                               32'hFFFF_FFFE, 32'd10, 32'hFFFF_FFFF};
    logic [W-1:0] bs  [11] = '{32'h0000_0024, 32'h0000_0024, 32'd5, 32'h0FF0_4321,
                               32'h00FF_0000, 32'h0F0F_FFFF, 32'hFFFF_FFE4, 32'hFFFF_FFFF,
                               32'h0000_0001, 32'd20, 32'd2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result_flags", {alu_result, eq, gt, lt, lt_s}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // ADD wrap with latency 1
    send(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    check("add_latency1", out_valid, 1);
    check("add_wrap_flags", {alu_result, eq, gt, lt, lt_s}, {32'd0, 4'b0101});

    // Back-to-back single-cycle ops at one per cycle
    t0 = cyc;
    foreach (ops[i]) send(ops[i], as[i], bs[i]);
    check("throughput_cycles", cyc - t0, 11);
    wait_drain();

    // MUL: busy window and exact latency
    send(OP_MUL, 32'h0001_0000, 32'h0003_0000);
    bad = 0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (!busy || in_ready || out_valid) bad++;
    end
    check("mul_busy_window", bad, 0);
    @(negedge clk);
    check("mul_latency", out_valid, 1);
    check("mul_idle_after", busy, 0);
    @(posedge clk);
    #1;

    // Remaining multi-cycle directed cases, then a few random ones
    send(OP_MULHU, 32'h0001_0000, 32'h0003_0000);
    send(OP_DIVU, 32'd100, 32'd7);
    send(OP_REMU, 32'd100, 32'd7);
    send(OP_DIVU, 32'd5, 32'd0);
    send(OP_REMU, 32'd5, 32'd0);
    for (int i = 0; i < 8; i++)
      send(4'(OP_MUL + 4'($urandom_range(0, 3))), $urandom, (i == 7) ? 32'd0 : $urandom);
    wait_drain();

    // Backpressure: result held, then drain and load in the same cycle
    out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd2);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!out_valid || alu_result !== 32'd3 || in_ready) bad++;
    end
    check("bp_hold", bad, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(OP_SUB, 32'd5, 32'd3);
    check("bp_valid_kept", out_valid, 1);
    check("bp_new_result", alu_result, 32'd2);
    wait_drain();

    // Reset during a divide
    send(OP_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result", alu_result, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(OP_ADD, 32'd2, 32'd2);
    check("post_rst_latency1", out_valid, 1);
    check("post_rst_result", alu_result, 32'd4);
    wait_drain();
    repeat (40) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
